alu_seq_ctrl: RTL and testbench

ALU_SEQ_CTRL -- requirements
Module: alu_seq_ctrl

---
 rtl/alu_seq_ctrl.sv | 174 +++++++++++++++++
 tb/tb_alu_seq_ctrl.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : alu_seq_ctrl                                                  |
// | Purpose  : Sequencing controller for an external combinational ALU.      |
// |            Owns an 8 x 32-bit register file (R0 hard-wired to zero),     |
// |            accepts one operation at a time and walks it through          |
// |            IDLE -> READ -> EXEC -> WB. The result appears on out_* in     |
// |            the third cycle after acceptance.                             |
// | Ports    : clk, rst_n            - clock, async active-low reset         |
// |            in_valid/in_ready     - operation handshake                   |
// |            in_op/in_rd/rs/rt     - opcode and register indices           |
// |            ld_en/addr/data       - register preload port                 |
// |            alu_a/alu_b/alu_op    - registered operands to the ALU        |
// |            alu_result/zero/set/overflow/cout - ALU outputs                |
// |            out_valid/result/eq/ovf/illegal   - completion pulse + data   |
// |            dbg_addr/dbg_data     - combinational register-file read      |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module alu_seq_ctrl #(
  parameter bit TRAP_OVF = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  in_op,
  input  logic [2:0]  in_rd,
  input  logic [2:0]  in_rs,
  input  logic [2:0]  in_rt,
  input  logic        ld_en,
  input  logic [2:0]  ld_addr,
  input  logic [31:0] ld_data,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [2:0]  alu_op,
  input  logic [31:0] alu_result,
  input  logic        alu_zero,
  input  logic        alu_set,
  input  logic        alu_overflow,
  input  logic        alu_cout,
  output logic        out_valid,
  output logic [31:0] out_result,
  output logic        out_eq,
  output logic        out_ovf,
  output logic        out_illegal,
  input  logic [2:0]  dbg_addr,
  output logic [31:0] dbg_data
);

  localparam logic [2:0] c_OP_AND = 3'b000;
  localparam logic [2:0] c_OP_OR  = 3'b001;
  localparam logic [2:0] c_OP_ADD = 3'b010;
  localparam logic [2:0] c_OP_SUB = 3'b110;
  localparam logic [2:0] c_OP_SLT = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_READ = 2'd1,
    S_EXEC = 2'd2,
    S_WB   = 2'd3
  } state_t;

  state_t      r_state;
  logic [2:0]  r_op;
  logic [2:0]  r_rd;
  logic [2:0]  r_rs;
  logic [2:0]  r_rt;
  logic [31:0] r_regs [0:7];

  logic        w_legal;
  logic        w_arith;
  logic [31:0] w_result;
  logic        w_ovf;
  logic        w_wb_en;
  logic        w_unused;

  // Carry-out is not part of any reported flag.
  assign w_unused = alu_cout;

  // Result shaping during EXEC; alu_op holds the accepted opcode there.
  assign w_legal = (alu_op == c_OP_AND) || (alu_op == c_OP_OR) || (alu_op == c_OP_ADD) ||
                   (alu_op == c_OP_SUB) || (alu_op == c_OP_SLT);
  assign w_arith = (alu_op == c_OP_ADD) || (alu_op == c_OP_SUB);
  assign w_ovf   = w_arith & alu_overflow;

  always_comb begin
    w_result = 32'd0;
    if (alu_op == c_OP_SLT)
      w_result = {31'd0, alu_set};
    else if (w_legal)
      w_result = alu_result;
  end

  // Write-back is driven from the captured completion data, so it reflects
  // exactly what was reported on out_*.
  assign w_wb_en = (r_state == S_WB) && !out_illegal && !(TRAP_OVF && out_ovf);

  assign dbg_data = (dbg_addr == 3'd0) ? 32'd0 : r_regs[dbg_addr];

  // Control FSM with registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      in_ready    <= 1'b1;
      r_op        <= 3'd0;
      r_rd        <= 3'd0;
      r_rs        <= 3'd0;
      r_rt        <= 3'd0;
      alu_a       <= 32'd0;
      alu_b       <= 32'd0;
      alu_op      <= 3'd0;
      out_valid   <= 1'b0;
      out_result  <= 32'd0;
      out_eq      <= 1'b0;
      out_ovf     <= 1'b0;
      out_illegal <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_op     <= in_op;
            r_rd     <= in_rd;
            r_rs     <= in_rs;
            r_rt     <= in_rt;
            in_ready <= 1'b0;
            r_state  <= S_READ;
          end
        end
        S_READ: begin
          // Array read sees the pre-edge contents: a load landing on this
          // same edge is not forwarded.
          alu_a   <= r_regs[r_rs];
          alu_b   <= r_regs[r_rt];
          alu_op  <= r_op;
          r_state <= S_EXEC;
        end
        S_EXEC: begin
          out_result  <= w_result;
          out_eq      <= alu_zero;
          out_ovf     <= w_ovf;
          out_illegal <= ~w_legal;
          out_valid   <= 1'b1;
          r_state     <= S_WB;
        end
        S_WB: begin
          in_ready <= 1'b1;
          r_state  <= S_IDLE;
        end
        default: begin
          in_ready <= 1'b1;
          r_state  <= S_IDLE;
        end
      endcase
    end
  end

  // Register file: write-back has priority over the preload port, and a
  // preload is dropped entirely on a write-back edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) begin
        r_regs[i] <= 32'd0;
      end
    end else if (w_wb_en) begin
      if (r_rd != 3'd0)
        r_regs[r_rd] <= out_result;
    end else if (ld_en && (ld_addr != 3'd0)) begin
      r_regs[ld_addr] <= ld_data;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_alu_seq_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_alu_seq_ctrl                                               |
// | Purpose  : Directed self-checking bench for alu_seq_ctrl with a          |
// |            behavioural model of the external combinational ALU.          |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_alu_seq_ctrl;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_op;
  logic [2:0]  in_rd;
  logic [2:0]  in_rs;
  logic [2:0]  in_rt;
  logic        ld_en;
  logic [2:0]  ld_addr;
  logic [31:0] ld_data;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [2:0]  alu_op;
  logic [31:0] alu_result;
  logic        alu_zero;
  logic        alu_set;
  logic        alu_overflow;
  logic        alu_cout;
  logic        out_valid;
  logic [31:0] out_result;
  logic        out_eq;
  logic        out_ovf;
  logic        out_illegal;
  logic [2:0]  dbg_addr;
  logic [31:0] dbg_data;

  int total = 0;
  int bad   = 0;

  alu_seq_ctrl #(.TRAP_OVF(1'b1)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_op        (in_op),
    .in_rd        (in_rd),
    .in_rs        (in_rs),
    .in_rt        (in_rt),
    .ld_en        (ld_en),
    .ld_addr      (ld_addr),
    .ld_data      (ld_data),
    .alu_a        (alu_a),
    .alu_b        (alu_b),
    .alu_op       (alu_op),
    .alu_result   (alu_result),
    .alu_zero     (alu_zero),
    .alu_set      (alu_set),
    .alu_overflow (alu_overflow),
    .alu_cout     (alu_cout),
    .out_valid    (out_valid),
    .out_result   (out_result),
    .out_eq       (out_eq),
    .out_ovf      (out_ovf),
    .out_illegal  (out_illegal),
    .dbg_addr     (dbg_addr),
    .dbg_data     (dbg_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External ALU model. Reserved opcodes return a^b so a controller that
  // forgets to zero them is visible.
  logic [32:0] sum;
  always_comb begin
    sum          = 33'd0;
    alu_result   = 32'd0;
    alu_overflow = 1'b0;
    alu_cout     = 1'b0;
    alu_set      = ($signed(alu_a) < $signed(alu_b));
    alu_zero     = (alu_a == alu_b);
    case (alu_op)
      3'b000: alu_result = alu_a & alu_b;
      3'b001: alu_result = alu_a | alu_b;
      3'b010: begin
        sum          = {1'b0, alu_a} + {1'b0, alu_b};
        alu_result   = sum[31:0];
        alu_cout     = sum[32];
        alu_overflow = (alu_a[31] == alu_b[31]) && (sum[31] != alu_a[31]);
      end
      3'b110: begin
        sum          = {1'b0, alu_a} + {1'b0, ~alu_b} + 33'd1;
        alu_result   = sum[31:0];
        alu_cout     = sum[32];
        alu_overflow = (alu_a[31] != alu_b[31]) && (sum[31] != alu_a[31]);
      end
      3'b111: alu_result = {31'd0, alu_set};
      default: alu_result = alu_a ^ alu_b;
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic ld(input logic [2:0] a, input logic [31:0] d);
    ld_en   = 1'b1;
    ld_addr = a;
    ld_data = d;
    step();
    ld_en   = 1'b0;
  endtask

  task automatic reg_chk(input string tag, input logic [2:0] a, input logic [31:0] exp);
    dbg_addr = a;
    #1;
    chk(tag, dbg_data, exp);
  endtask

  // Full operation; returns just after the closing edge of WB.
  // With hold=1, in_valid stays high for the whole operation.
  task automatic do_op(input string tag, input logic [2:0] op, input logic [2:0] rd,
                       input logic [2:0] rs, input logic [2:0] rt, input bit hold);
    in_op    = op;
    in_rd    = rd;
    in_rs    = rs;
    in_rt    = rt;
    in_valid = 1'b1;
    step();                       // acceptance edge
    if (!hold) in_valid = 1'b0;
    @(negedge clk);               // cycle 1: READ
    chk({tag, ".c1_valid"}, {31'd0, out_valid}, 32'd0);
    chk({tag, ".c1_ready"}, {31'd0, in_ready}, 32'd0);
    step();
    @(negedge clk);               // cycle 2: EXEC
    chk({tag, ".c2_valid"}, {31'd0, out_valid}, 32'd0);
    step();
    @(negedge clk);               // cycle 3: WB
    chk({tag, ".c3_valid"}, {31'd0, out_valid}, 32'd1);
    step();
    in_valid = 1'b0;
  endtask

  initial begin
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_op    = 3'd0;
    in_rd    = 3'd0;
    in_rs    = 3'd0;
    in_rt    = 3'd0;
    ld_en    = 1'b0;
    ld_addr  = 3'd0;
    ld_data  = 32'd0;
    dbg_addr = 3'd0;

    // Reset state
    step();
    step();
    chk("rst.out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst.out_result", out_result, 32'd0);
    chk("rst.alu_a", alu_a, 32'd0);
    chk("rst.alu_op", {29'd0, alu_op}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst.in_ready", {31'd0, in_ready}, 32'd1);
    step();

    // 5 + 7, in_valid held high throughout (no queuing expected)
    ld(3'd1, 32'd5);
    ld(3'd2, 32'd7);
    do_op("add", 3'b010, 3'd3, 3'd1, 3'd2, 1'b1);
    chk("add.result", out_result, 32'd12);
    chk("add.ovf", {31'd0, out_ovf}, 32'd0);
    chk("add.alu_a", alu_a, 32'd5);
    chk("add.alu_b", alu_b, 32'd7);
    reg_chk("add.R3", 3'd3, 32'd12);
    @(negedge clk);
    chk("noqueue.ready0", {31'd0, in_ready}, 32'd1);
    step();
    @(negedge clk);
    chk("noqueue.ready1", {31'd0, in_ready}, 32'd1);
    step();

    // Signed overflow, trapped write
    ld(3'd1, 32'h7FFF_FFFF);
    ld(3'd2, 32'd1);
    do_op("ovf", 3'b010, 3'd4, 3'd1, 3'd2, 1'b0);
    chk("ovf.result", out_result, 32'h8000_0000);
    chk("ovf.ovf", {31'd0, out_ovf}, 32'd1);
    reg_chk("ovf.R4", 3'd4, 32'd0);

    // SLT both ways, then SUB of equal operands
    ld(3'd1, 32'd3);
    ld(3'd2, 32'd9);
    do_op("slt1", 3'b111, 3'd5, 3'd1, 3'd2, 1'b0);
    chk("slt1.result", out_result, 32'd1);
    chk("slt1.ovf", {31'd0, out_ovf}, 32'd0);
    reg_chk("slt1.R5", 3'd5, 32'd1);
    do_op("slt0", 3'b111, 3'd5, 3'd2, 3'd1, 1'b0);
    chk("slt0.result", out_result, 32'd0);
    reg_chk("slt0.R5", 3'd5, 32'd0);
    do_op("sub", 3'b110, 3'd2, 3'd1, 3'd1, 1'b0);
    chk("sub.result", out_result, 32'd0);
    chk("sub.eq", {31'd0, out_eq}, 32'd1);
    reg_chk("sub.R2", 3'd2, 32'd0);

    // Reserved opcode (R1=3, R2=0; model would return 3)
    ld(3'd6, 32'h55);
    do_op("ill", 3'b101, 3'd6, 3'd1, 3'd2, 1'b0);
    chk("ill.illegal", {31'd0, out_illegal}, 32'd1);
    chk("ill.result", out_result, 32'd0);
    reg_chk("ill.R6", 3'd6, 32'h55);

    // Write to R0 is discarded
    do_op("r0", 3'b010, 3'd0, 3'd1, 3'd1, 1'b0);
    chk("r0.result", out_result, 32'd6);
    chk("r0.illegal", {31'd0, out_illegal}, 32'd0);
    reg_chk("r0.R0", 3'd0, 32'd0);
    step();
    step();
    chk("hold.result", out_result, 32'd6);

    // Load to R1 on the READ edge is not bypassed; load to R7 in WB dropped
    in_op    = 3'b010;
    in_rd    = 3'd3;
    in_rs    = 3'd1;
    in_rt    = 3'd1;
    in_valid = 1'b1;
    step();                       // accept
    in_valid = 1'b0;
    ld(3'd1, 32'd100);            // lands on the READ closing edge
    chk("byp.alu_a", alu_a, 32'd3);
    step();                       // now in WB
    ld_en   = 1'b1;
    ld_addr = 3'd7;
    ld_data = 32'hAA;
    @(negedge clk);
    chk("byp.valid", {31'd0, out_valid}, 32'd1);
    step();
    ld_en = 1'b0;
    chk("byp.result", out_result, 32'd6);
    reg_chk("wbprio.R7", 3'd7, 32'd0);
    reg_chk("wbprio.R3", 3'd3, 32'd6);
    reg_chk("byp.R1", 3'd1, 32'd100);

    // Reset during EXEC aborts the operation
    in_op    = 3'b010;
    in_rd    = 3'd5;
    in_rs    = 3'd1;
    in_rt    = 3'd1;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();                       // EXEC
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort.valid", {31'd0, out_valid}, 32'd0);
    chk("abort.alu_a", alu_a, 32'd0);
    reg_chk("abort.R1", 3'd1, 32'd0);
    reg_chk("abort.R3", 3'd3, 32'd0);
    step();
    step();
    rst_n = 1'b1;
    @(negedge clk);
    chk("abort.ready", {31'd0, in_ready}, 32'd1);
    for (int i = 0; i < 4; i++) begin
      step();
      @(negedge clk);
      chk("abort.novalid", {31'd0, out_valid}, 32'd0);
    end
    reg_chk("abort.R5", 3'd5, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
